// File: rtl/hardware_unservice.sv
// Slot-frame unservicer: accepts a 4-slot frame and emits each occupied slot (tag 2'b10) in index order.
// Optional frame counter port enabled by HARDWARE_UNSERVICE_FRAME_COUNT_EN.
module hardware_unservice (
  input  logic         system1000,
  input  logic         system1000_rst,
  input  logic [319:0] frame_i,
  input  logic         frame_valid_i,
  output logic         frame_ready_o,
  output logic [94:0]  word_o,
  output logic [1:0]   word_idx_o,
  output logic         word_valid_o,
  input  logic         word_ready_i,
  output logic         word_last_o,
  output logic         busy_o
`ifdef HARDWARE_UNSERVICE_FRAME_COUNT_EN
  ,output logic [15:0] frame_count_o
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  mask_in;
  logic [94:0] slot_in [4];
  logic [94:0] slot_q  [4];
  logic [94:0] word_d;
  logic [1:0]  idx_d;
  logic        valid_d, last_d;
  logic        accept, take;

  function automatic logic [1:0] first_idx(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Clears the lowest set bit, i.e. the slot just presented.
  function automatic logic [3:0] clear_first(input logic [3:0] m);
    return m & 4'(m - 4'd1);
  endfunction

  assign frame_ready_o = (state_q == IDLE);
  assign busy_o        = (state_q == SEND);
  assign accept        = frame_ready_o && frame_valid_i;
  assign take          = word_valid_o && word_ready_i;

  always_comb begin
    slot_in[0] = {frame_i[319:318], 30'b0, frame_i[317:255]};
    slot_in[1] = {frame_i[254:253], 30'b0, frame_i[252:190]};
    slot_in[2] = frame_i[189:95];
    slot_in[3] = frame_i[94:0];
    for (int i = 0; i < 4; i++) mask_in[i] = (slot_in[i][94:93] == 2'b10);
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    mask_d  = mask_q;
    word_d  = word_o;
    idx_d   = word_idx_o;
    valid_d = word_valid_o;
    last_d  = word_last_o;
    case (state_q)
      IDLE: begin
        if (accept && (mask_in != 4'd0)) begin
          // NOTE: blocking assignments here, so idx_d and mask_d are read back with their new values below.
          state_d = SEND;
          idx_d   = first_idx(mask_in);
          word_d  = slot_in[idx_d];
          mask_d  = clear_first(mask_in);
          last_d  = (mask_d == 4'd0);
          valid_d = 1'b1;
        end
      end
      SEND: begin
        if (take) begin
          if (word_last_o) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            idx_d  = first_idx(mask_q);
            word_d = slot_q[idx_d];
            mask_d = clear_first(mask_q);
            last_d = (mask_d == 4'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments for all flops; reset wins over any handshake in the same cycle.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q      <= IDLE;
      mask_q       <= 4'd0;
      word_o       <= '0;
      word_idx_o   <= 2'd0;
      word_valid_o <= 1'b0;
      word_last_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      word_o       <= word_d;
      word_idx_o   <= idx_d;
      word_valid_o <= valid_d;
      word_last_o  <= last_d;
    end
  end

  // NOTE: slot storage is not reset; it is only read while the mask, which is reset, marks it live.
  always_ff @(posedge system1000) begin
    if (accept) begin
      for (int i = 0; i < 4; i++) slot_q[i] <= slot_in[i];
    end
  end

`ifdef HARDWARE_UNSERVICE_FRAME_COUNT_EN
  // Counts every accepted frame, empty ones included; wraps naturally at 16 bits.
  always_ff @(posedge system1000) begin
    if (system1000_rst)  frame_count_o <= 16'd0;
    else if (accept)     frame_count_o <= frame_count_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hardware_unservice.sv
// Directed self-checking bench for hardware_unservice; counter checks run when
// HARDWARE_UNSERVICE_FRAME_COUNT_EN is defined.
module tb_hardware_unservice;

  logic         clk = 1'b0;
  logic         rst;
  logic [319:0] frame_i;
  logic         frame_valid_i;
  logic         frame_ready_o;
  logic [94:0]  word_o;
  logic [1:0]   word_idx_o;
  logic         word_valid_o;
  logic         word_ready_i;
  logic         word_last_o;
  logic         busy_o;
`ifdef HARDWARE_UNSERVICE_FRAME_COUNT_EN
  logic [15:0]  frame_count_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hardware_unservice dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .frame_i        (frame_i),
    .frame_valid_i  (frame_valid_i),
    .frame_ready_o  (frame_ready_o),
    .word_o         (word_o),
    .word_idx_o     (word_idx_o),
    .word_valid_o   (word_valid_o),
    .word_ready_i   (word_ready_i),
    .word_last_o    (word_last_o),
    .busy_o         (busy_o)
`ifdef HARDWARE_UNSERVICE_FRAME_COUNT_EN
   ,.frame_count_o  (frame_count_o)
`endif
  );

  task automatic check(input string tag, input logic [94:0] obs, input logic [94:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [319:0] mk(input logic [64:0] s0, input logic [64:0] s1,
                                      input logic [94:0] s2, input logic [94:0] s3);
    return {s0, s1, s2, s3};
  endfunction

  logic [319:0] f_sparse, f_empty, f_full;

  initial begin
    f_sparse = mk({2'b10, 63'h5}, {2'b01, 63'h0}, {2'b10, 93'h7}, {2'b00, 93'h0});
    f_empty  = mk({2'b01, 63'h1}, {2'b01, 63'h2}, {2'b01, 93'h3}, {2'b01, 93'h4});
    f_full   = mk({2'b10, 63'h11}, {2'b10, 63'h22}, {2'b10, 93'h33}, {2'b10, 93'h44});

    rst = 1'b1; frame_i = '0; frame_valid_i = 1'b0; word_ready_i = 1'b1;
    tick(); tick();
    check("rst_valid", 95'(word_valid_o), 95'(0));
    check("rst_busy",  95'(busy_o), 95'(0));
    check("rst_word",  word_o, 95'(0));
    check("rst_idx",   95'(word_idx_o), 95'(0));
    check("rst_last",  95'(word_last_o), 95'(0));
`ifdef HARDWARE_UNSERVICE_FRAME_COUNT_EN
    check("rst_count", 95'(frame_count_o), 95'(0));
`endif
    rst = 1'b0;
    tick();
    check("ready_after_rst", 95'(frame_ready_o), 95'(1));

    // Sparse frame: slots 0 and 2 occupied.
    frame_i = f_sparse; frame_valid_i = 1'b1;
    tick();
    frame_valid_i = 1'b0;
    check("sp_w0_valid", 95'(word_valid_o), 95'(1));
    check("sp_w0_idx",   95'(word_idx_o), 95'(0));
    check("sp_w0_word",  word_o, {2'b10, 30'b0, 63'h5});
    check("sp_w0_last",  95'(word_last_o), 95'(0));
    check("sp_busy",     95'(busy_o), 95'(1));
    check("sp_not_ready", 95'(frame_ready_o), 95'(0));
    tick();
    check("sp_w1_valid", 95'(word_valid_o), 95'(1));
    check("sp_w1_idx",   95'(word_idx_o), 95'(2));
    check("sp_w1_word",  word_o, {2'b10, 93'h7});
    check("sp_w1_last",  95'(word_last_o), 95'(1));
    check("sp_no_overlap", 95'(frame_ready_o), 95'(0));
    tick();
    check("sp_done_valid", 95'(word_valid_o), 95'(0));
    check("sp_done_ready", 95'(frame_ready_o), 95'(1));
    check("sp_done_busy",  95'(busy_o), 95'(0));

    // Frame with no occupied slot: consumed, nothing emitted.
    frame_i = f_empty; frame_valid_i = 1'b1;
    tick();
    frame_valid_i = 1'b0;
    check("em_valid", 95'(word_valid_o), 95'(0));
    check("em_ready", 95'(frame_ready_o), 95'(1));
    check("em_busy",  95'(busy_o), 95'(0));
`ifdef HARDWARE_UNSERVICE_FRAME_COUNT_EN
    check("em_count", 95'(frame_count_o), 95'(2));
`endif

    // Full frame with backpressure on idx 1; a competing frame is offered meanwhile.
    frame_i = f_full; frame_valid_i = 1'b1;
    tick();
    frame_i = f_sparse;
    check("fu_w0_idx",  95'(word_idx_o), 95'(0));
    check("fu_w0_word", word_o, {2'b10, 30'b0, 63'h11});
    tick();
    check("fu_w1_idx",  95'(word_idx_o), 95'(1));
    check("fu_w1_word", word_o, {2'b10, 30'b0, 63'h22});
    word_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fu_hold_valid", 95'(word_valid_o), 95'(1));
      check("fu_hold_idx",   95'(word_idx_o), 95'(1));
      check("fu_hold_word",  word_o, {2'b10, 30'b0, 63'h22});
      check("fu_hold_last",  95'(word_last_o), 95'(0));
    end
    word_ready_i = 1'b1;
    frame_valid_i = 1'b0;
    tick();
    check("fu_w2_idx",  95'(word_idx_o), 95'(2));
    check("fu_w2_word", word_o, {2'b10, 93'h33});
    check("fu_w2_last", 95'(word_last_o), 95'(0));
    tick();
    check("fu_w3_idx",  95'(word_idx_o), 95'(3));
    check("fu_w3_word", word_o, {2'b10, 93'h44});
    check("fu_w3_last", 95'(word_last_o), 95'(1));
    tick();
    check("fu_done_valid", 95'(word_valid_o), 95'(0));
    check("fu_done_ready", 95'(frame_ready_o), 95'(1));
`ifdef HARDWARE_UNSERVICE_FRAME_COUNT_EN
    check("fu_count", 95'(frame_count_o), 95'(3));
`endif

    // Reset while idx 1 is pending and being handshaken.
    frame_i = f_full; frame_valid_i = 1'b1;
    tick();
    frame_valid_i = 1'b0;
    tick();
    check("mr_pending_idx", 95'(word_idx_o), 95'(1));
    rst = 1'b1;
    tick();
    check("mr_valid", 95'(word_valid_o), 95'(0));
    check("mr_busy",  95'(busy_o), 95'(0));
    rst = 1'b0;
    check("mr_ready", 95'(frame_ready_o), 95'(1));
    tick();
    check("mr_no_residual", 95'(word_valid_o), 95'(0));
    frame_i = f_sparse; frame_valid_i = 1'b1;
    tick();
    frame_valid_i = 1'b0;
    check("mr_next_idx",  95'(word_idx_o), 95'(0));
    check("mr_next_word", word_o, {2'b10, 30'b0, 63'h5});
    tick(); tick();
    check("mr_next_done", 95'(frame_ready_o), 95'(1));

`ifdef HARDWARE_UNSERVICE_FRAME_COUNT_EN
    check("wr_start", 95'(frame_count_o), 95'(1));
    frame_i = f_empty; frame_valid_i = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    check("wr_max", 95'(frame_count_o), 95'(16'hFFFF));
    tick();
    frame_valid_i = 1'b0;
    check("wr_zero", 95'(frame_count_o), 95'(0));
    check("wr_valid", 95'(word_valid_o), 95'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hardware_unservice.md
HARDWARE_UNSERVICE -- requirements
Module: hardware_unservice

Interface
REQ-001 SHALL have ports: system1000  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: system1000_rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: frame_i  in  320  slot frame {slot0[64:0], slot1[64:0], slot2[94:0], slot3[94:0]}; slot0 at MSBs.
REQ-004 SHALL have ports: frame_valid_i  in  1  upstream frame valid.
REQ-005 SHALL have ports: frame_ready_o  out  1  block accepts a frame this cycle.
REQ-006 SHALL have ports: word_o  out  95  emitted slot word.
REQ-007 SHALL have ports: word_idx_o  out  2  index (0..3) of emitted slot.
REQ-008 SHALL have ports: word_valid_o  out  1; word_ready_i  in  1; word_last_o  out  1 (final word of frame).
REQ-009 SHALL have ports: busy_o  out  1  frame held, not fully drained.
REQ-010 SHALL have port frame_count_o  out  16, present only under REQ-027.

Function
REQ-011 Slot tag = top 2 bits of slot; 2'b10 = occupied term; 2'b00, 2'b01, 2'b11 = unoccupied, never emitted.
REQ-012 Word format: 95-bit slots verbatim; 65-bit slots as {tag[1:0], 30'b0, payload[62:0]}.
REQ-013 States: IDLE, SEND; frame_ready_o = 1 only in IDLE; busy_o = 1 only in SEND.
REQ-014 IDLE, frame_valid_i & frame_ready_o: register frame, compute 4-bit occupancy mask.
REQ-015 Mask zero: frame consumed, stay IDLE, no word emitted.
REQ-016 Mask nonzero: enter SEND next cycle, word_valid_o = 1 with lowest-index occupied slot; latency acceptance -> first word = 1 cycle.
REQ-017 All word_* outputs registered; word_o, word_idx_o, word_last_o stable while word_valid_o & !word_ready_i.
REQ-018 word_last_o = 1 iff no higher-index occupied slot remains in mask.
REQ-019 Word handshake (valid & ready), not last: clear mask bit, present next occupied slot next cycle; one word per cycle at full throughput.
REQ-020 Handshake on last word: word_valid_o = 0 and IDLE next cycle; frame_ready_o not asserted in same cycle as last handshake (no frame overlap).
REQ-021 word_ready_i while word_valid_o = 0 SHALL be ignored; frame_valid_i outside IDLE ignored, frame_i not sampled.
REQ-022 Frame of n occupied slots consumes exactly 1 + n cycles at constant ready.

Reset
REQ-023 On system1000_rst: state IDLE, mask 0, word_o 0, word_idx_o 0, word_valid_o 0, word_last_o 0, busy_o 0, frame_count_o 0.
REQ-024 frame_ready_o = 1 first cycle after reset deasserts.
REQ-025 Reset mid-SEND discards held frame; no residual word emitted after reset.
REQ-026 Reset overrides simultaneous handshakes in same cycle.

Configuration
REQ-027 Macro HARDWARE_UNSERVICE_FRAME_COUNT_EN: defined -> frame_count_o present, +1 per accepted frame (incl. empty frames, REQ-015), wraps 16'hFFFF -> 16'h0000; undefined -> port and counter absent, all else identical.

Verification
REQ-028 Frame slot0={2'b10,63'h5}, slot1={2'b01,0}, slot2={2'b10,93'h7}, slot3={2'b00,0}, ready=1 -> words idx 0 ({2'b10,30'b0,63'h5}, last 0), idx 2 ({2'b10,93'h7}, last 1) on consecutive cycles; frame_ready_o back 1 cycle later.
REQ-029 All four tags 2'b01 -> no word_valid_o, stays IDLE, frame_count_o +1 (macro on).
REQ-030 All four occupied, word_ready_i low 3 cycles on idx 1 -> idx 1 word held stable, then idx 2, idx 3 (last 1); 4 words total, none dropped or duplicated.
REQ-031 Reset asserted while idx 1 pending -> next cycle word_valid_o 0, busy_o 0, frame_ready_o 1 after reset; next frame emitted from its own idx 0.
REQ-032 Macro on, 65536 empty frames -> frame_count_o wraps to 0; macro off -> build has no frame_count_o, REQ-028 trace unchanged.
